// File: rtl/cpu_pkg.sv
// Shared RV64 core definitions: machine widths, canonical NOP, base opcodes and
// the fetch-buffer entry layout used between fetch and decode.
package cpu_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: {pc, inst} FIFO plus a queue of issued-but-unanswered fetch PCs
// that tags each returning instruction word with the address it was fetched from.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_flush,
    input  logic            i_issue,
    input  logic [XLEN-1:0] i_issue_pc,
    input  logic            i_push,
    input  logic [ILEN-1:0] i_push_inst,
    input  logic            i_pop,
    output fetch_entry_t    o_head,
    output logic [CW-1:0]   o_count,
    output logic            o_full,
    output logic            o_empty
);

    fetch_entry_t    r_data [DEPTH];
    logic [XLEN-1:0] r_pcq  [DEPTH];
    logic [PW-1:0]   r_rd;
    logic [PW-1:0]   r_wr;
    logic [PW-1:0]   r_pq_rd;
    logic [PW-1:0]   r_pq_wr;
    logic [CW-1:0]   r_count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_pq_rd <= '0;
            r_pq_wr <= '0;
            r_count <= '0;
        end else begin
            if (i_issue) r_pq_wr <= ptr_inc(r_pq_wr);
            if (i_push) begin
                r_wr    <= ptr_inc(r_wr);
                r_pq_rd <= ptr_inc(r_pq_rd);
            end
            if (i_pop) r_rd <= ptr_inc(r_rd);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    // Storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (!rst && !i_flush) begin
            if (i_issue) r_pcq[r_pq_wr] <= i_issue_pc;
            if (i_push)  r_data[r_wr]   <= '{pc: r_pcq[r_pq_rd], inst: i_push_inst};
        end
    end

    assign o_head  = r_data[r_rd];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_unit.sv
// RV64 instruction-fetch stage: PC generation, in-order imem requests, fetch
// buffering and wrong-path squashing on execute-stage redirects.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 64'h0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    output logic            inst_valid
);

    localparam int CW = $clog2(DEPTH + 1);
    // Wrong-path words can pile up across back-to-back redirects, so the
    // drop counter needs headroom beyond DEPTH.
    localparam int DW = $clog2(2 * DEPTH + 1);

    logic [XLEN-1:0] r_fetch_pc;
    logic [CW-1:0]   r_outstanding;
    logic [DW-1:0]   r_drop_cnt;

    fetch_entry_t    w_head;
    logic [CW-1:0]   w_count;
    logic            w_full;
    logic            w_empty;
    logic [CW:0]     w_inflight;
    logic            w_issue;
    logic            w_drop;
    logic            w_keep;
    logic            w_push;
    logic            w_pop;

    assign w_inflight     = {1'b0, r_outstanding} + {1'b0, w_count};
    assign imem_req_valid = !rst && (w_inflight < (CW+1)'(DEPTH)) && !redirect_valid;
    assign imem_req_addr  = r_fetch_pc;

    assign w_issue = imem_req_valid && imem_req_ready;
    assign w_drop  = imem_rsp_valid && (r_drop_cnt != '0);
    assign w_keep  = imem_rsp_valid && !w_drop;
    assign w_push  = w_keep && !w_full;
    assign w_pop   = inst_valid && !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else if (redirect_valid) begin
            // Every word still in flight after this cycle belongs to the old path.
            r_fetch_pc    <= word_align(redirect_pc);
            r_outstanding <= '0;
            r_drop_cnt    <= DW'(r_outstanding) + r_drop_cnt - DW'(imem_rsp_valid);
        end else begin
            if (w_issue) r_fetch_pc <= r_fetch_pc + 64'd4;
            r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_keep);
            r_drop_cnt    <= r_drop_cnt - DW'(w_drop);
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (redirect_valid),
        .i_issue     (w_issue),
        .i_issue_pc  (r_fetch_pc),
        .i_push      (w_push),
        .i_push_inst (imem_rsp_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign inst_valid = !w_empty;
    assign inst       = inst_valid ? w_head.inst : NOP_INST;
    assign pc         = inst_valid ? w_head.pc   : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order, fixed-latency instruction memory
// whose word at address A is 32'hC0DE0000 | A[15:0].
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        stall;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        inst_valid;

    int n_vec = 0;
    int n_bad = 0;
    int lat   = 1;
    int cyc   = 0;

    logic [63:0] mq_addr[$];
    int          mq_due[$];

    fetch_unit #(.RESET_PC(64'h0), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .inst           (inst),
        .pc             (pc),
        .inst_valid     (inst_valid)
    );

    always #5 clk = ~clk;

    // Instruction memory: request accepted in cycle t answers in cycle t+lat.
    always @(posedge clk) begin
        if (rst) begin
            mq_addr.delete();
            mq_due.delete();
        end else begin
            if (imem_rsp_valid) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                mq_addr.push_back(imem_req_addr);
                mq_due.push_back(cyc + lat);
            end
        end
        cyc++;
        #1;
        if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hC0DE_0000 | {16'h0, mq_addr[0][15:0]};
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        #1;
    endtask

    // Waits (bounded) for the next valid instruction, checks it, then consumes it.
    task automatic expect_next(input string tag, input logic [63:0] epc);
        for (int k = 0; k < 20 && !inst_valid; k++) step();
        chk({tag, "_valid"}, 64'(inst_valid), 64'd1);
        if (inst_valid) begin
            chk({tag, "_pc"}, pc, epc);
            chk({tag, "_inst"}, 64'(inst), 64'(32'hC0DE_0000 | {16'h0, epc[15:0]}));
        end
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        repeat (3) step();

        chk("rst_req_valid",  64'(imem_req_valid), 64'd0);
        chk("rst_req_addr",   imem_req_addr,       64'h0);
        chk("rst_inst",       64'(inst),           64'h13);
        chk("rst_pc",         pc,                  64'h0);
        chk("rst_inst_valid", 64'(inst_valid),     64'd0);

        // Reset release, L=1: streaming and first-output latency.
        rst = 1'b0;
        #1;
        chk("c0_req_valid", 64'(imem_req_valid), 64'd1);
        chk("c0_req_addr",  imem_req_addr,       64'h0);
        step();
        chk("c1_inst_valid", 64'(inst_valid), 64'd0);
        chk("c1_req_addr",   imem_req_addr,   64'h4);
        step();
        chk("c2_inst_valid", 64'(inst_valid), 64'd1);
        chk("c2_pc",         pc,              64'h0);
        chk("c2_inst",       64'(inst),       64'hC0DE_0000);
        step();
        chk("c3_pc", pc, 64'h4);

        // Decode stall: head frozen, FIFO fills, requests stop.
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 64'(inst_valid), 64'd1);
            chk("stall_pc",    pc,              64'h4);
            if (i >= 2) chk("stall_req_off", 64'(imem_req_valid), 64'd0);
            step();
        end
        stall = 1'b0;
        expect_next("post_stall_4",  64'h4);
        expect_next("post_stall_8",  64'h8);
        expect_next("post_stall_c",  64'hC);
        expect_next("post_stall_10", 64'h10);

        // Memory not ready: address held, fetch PC not advanced.
        do_reset();
        expect_next("rdy_0", 64'h0);
        imem_req_ready = 1'b0;
        expect_next("rdy_4", 64'h4);
        for (int i = 0; i < 3; i++) begin
            chk("rdy_hold_valid", 64'(imem_req_valid), 64'd1);
            chk("rdy_hold_addr",  imem_req_addr,       64'h8);
            step();
        end
        imem_req_ready = 1'b1;
        #1;
        chk("rdy_resume_addr", imem_req_addr, 64'h8);
        expect_next("rdy_8", 64'h8);
        expect_next("rdy_c", 64'hC);

        // Redirect with two requests outstanding, L=3: both old words squashed.
        lat = 3;
        do_reset();
        step();
        step();
        chk("rd3_full_req_off", 64'(imem_req_valid), 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("rd3_inst_valid", 64'(inst_valid),     64'd0);
        chk("rd3_inst_nop",   64'(inst),           64'h13);
        chk("rd3_pc_zero",    pc,                  64'h0);
        chk("rd3_req_valid",  64'(imem_req_valid), 64'd1);
        chk("rd3_req_addr",   imem_req_addr,       64'h100);
        expect_next("rd3_100", 64'h100);
        expect_next("rd3_104", 64'h104);

        // Unaligned redirect coinciding with a response and a pop, L=1.
        lat = 1;
        do_reset();
        step();
        step();
        chk("rd1_head_pc", pc, 64'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h203;
        #1;
        chk("rd1_req_blocked", 64'(imem_req_valid), 64'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("rd1_flushed",   64'(inst_valid),     64'd0);
        chk("rd1_req_valid", 64'(imem_req_valid), 64'd1);
        chk("rd1_req_addr",  imem_req_addr,       64'h200);
        step();
        chk("rd1_still_empty", 64'(inst_valid), 64'd0);
        expect_next("rd1_200", 64'h200);
        expect_next("rd1_204", 64'h204);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        expect_next("wrap_top",  64'hFFFF_FFFF_FFFF_FFFC);
        expect_next("wrap_zero", 64'h0);
        expect_next("wrap_four", 64'h4);

        // Reset in the middle of a stream.
        rst = 1'b1;
        #1;
        chk("mid_rst_req_off", 64'(imem_req_valid), 64'd0);
        step();
        chk("mid_rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("mid_rst_inst",       64'(inst),       64'h13);
        chk("mid_rst_pc",         pc,              64'h0);
        chk("mid_rst_addr",       imem_req_addr,   64'h0);
        rst = 1'b0;
        #1;
        chk("mid_rst_restart", 64'(imem_req_valid), 64'd1);
        expect_next("mid_rst_0", 64'h0);
        expect_next("mid_rst_4", 64'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
